// File: rtl/uart_pkg.sv
// Shared UART constants: default baud generator widths and the x16 oversample ratio.
package uart_pkg;

    localparam int unsigned UART_CNT_W     = 13;
    localparam int unsigned UART_FRAC_W    = 3;
    localparam int unsigned UART_OVS_RATIO = 16;
    localparam int unsigned UART_OVS_W     = $clog2(UART_OVS_RATIO);

endpackage

// File: rtl/uart_baud_gen_frac.sv
// Fractional baud-rate generator: oversample tick, per-bit pulse, glitch-free reconfiguration.
// Define UART_BAUD_FRAC_EN to build the fractional carry-accumulator path.
module uart_baud_gen_frac
    import uart_pkg::*;
#(
    parameter int unsigned        CNT_W    = UART_CNT_W,
    parameter int unsigned        FRAC_W   = UART_FRAC_W,
    parameter int unsigned        OVS_W    = UART_OVS_W,
    parameter logic [CNT_W-1:0]   BAUD_RST = '0,
    parameter logic [FRAC_W-1:0]  FRAC_RST = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              phase_clr,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CNT_W-1:0]  cfg_baud_val,
    input  logic [FRAC_W-1:0] cfg_baud_frac,
    output logic              baud_tick,
    output logic              xmit_pulse,
    output logic [OVS_W-1:0]  ovs_phase
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [OVS_W-1:0] OVS_ONE = OVS_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OVS_W-1:0] ovs_cntr_q, ovs_cntr_d;
    logic [CNT_W-1:0] baud_val_q, baud_val_d;
    logic [CNT_W-1:0] shadow_val_q, shadow_val_d;
    logic             pend_q, pend_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             baud_tick_q, baud_tick_d;
    logic             xmit_pulse_q, xmit_pulse_d;
    logic             apply;

`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              stretch_q, stretch_d;
    logic [FRAC_W-1:0] baud_frac_q, baud_frac_d;
    logic [FRAC_W-1:0] shadow_frac_q, shadow_frac_d;
`else
    logic unused_frac;
    assign unused_frac = ^{cfg_baud_frac, FRAC_RST};
`endif

    always_comb begin
        cnt_d        = cnt_q;
        ovs_cntr_d   = ovs_cntr_q;
        baud_val_d   = baud_val_q;
        shadow_val_d = shadow_val_q;
        pend_d       = pend_q;
        cfg_ready_d  = cfg_ready_q;
        baud_tick_d  = 1'b0;
        xmit_pulse_d = 1'b0;
`ifdef UART_BAUD_FRAC_EN
        acc_d         = acc_q;
        stretch_d     = stretch_q;
        baud_frac_d   = baud_frac_q;
        shadow_frac_d = shadow_frac_q;
`endif

        if (!en || phase_clr) begin
            cnt_d      = '0;
            ovs_cntr_d = '0;
`ifdef UART_BAUD_FRAC_EN
            acc_d     = '0;
            stretch_d = 1'b0;
`endif
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
`ifdef UART_BAUD_FRAC_EN
        end else if (stretch_q) begin
            stretch_d = 1'b0;
`endif
        end else begin
            cnt_d        = baud_val_q;
            baud_tick_d  = 1'b1;
            xmit_pulse_d = (ovs_cntr_q == '1);
            ovs_cntr_d   = ovs_cntr_q + OVS_ONE;
`ifdef UART_BAUD_FRAC_EN
            {stretch_d, acc_d} = {1'b0, acc_q} + {1'b0, baud_frac_q};
`endif
        end

        // A bit-boundary apply overrides this cycle's reload so the new divisor takes effect at once.
        apply = pend_q && (!en || phase_clr || xmit_pulse_d);
        if (apply) begin
            baud_val_d  = shadow_val_q;
            pend_d      = 1'b0;
            cfg_ready_d = 1'b1;
            if (xmit_pulse_d) begin
                cnt_d = shadow_val_q;
            end
`ifdef UART_BAUD_FRAC_EN
            baud_frac_d = shadow_frac_q;
            acc_d       = '0;
            stretch_d   = 1'b0;
`endif
        end else if (cfg_valid && cfg_ready_q) begin
            shadow_val_d = cfg_baud_val;
            pend_d       = 1'b1;
            cfg_ready_d  = 1'b0;
`ifdef UART_BAUD_FRAC_EN
            shadow_frac_d = cfg_baud_frac;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q        <= '0;
            ovs_cntr_q   <= '0;
            baud_val_q   <= BAUD_RST;
            shadow_val_q <= '0;
            pend_q       <= 1'b0;
            cfg_ready_q  <= 1'b1;
            baud_tick_q  <= 1'b0;
            xmit_pulse_q <= 1'b0;
`ifdef UART_BAUD_FRAC_EN
            acc_q         <= '0;
            stretch_q     <= 1'b0;
            baud_frac_q   <= FRAC_RST;
            shadow_frac_q <= '0;
`endif
        end else begin
            cnt_q        <= cnt_d;
            ovs_cntr_q   <= ovs_cntr_d;
            baud_val_q   <= baud_val_d;
            shadow_val_q <= shadow_val_d;
            pend_q       <= pend_d;
            cfg_ready_q  <= cfg_ready_d;
            baud_tick_q  <= baud_tick_d;
            xmit_pulse_q <= xmit_pulse_d;
`ifdef UART_BAUD_FRAC_EN
            acc_q         <= acc_d;
            stretch_q     <= stretch_d;
            baud_frac_q   <= baud_frac_d;
            shadow_frac_q <= shadow_frac_d;
`endif
        end
    end

    assign cfg_ready  = cfg_ready_q;
    assign baud_tick  = baud_tick_q;
    assign xmit_pulse = xmit_pulse_q;
    assign ovs_phase  = ovs_cntr_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Directed bench for uart_baud_gen_frac: tick spacing table plus bit-boundary, resync and reset sequences.
module tb_uart_baud_gen_frac;

    localparam int unsigned CNT_W  = 13;
    localparam int unsigned FRAC_W = 3;
    localparam int unsigned OVS_W  = 4;
`ifdef UART_BAUD_FRAC_EN
    localparam bit FRAC_ON = 1'b1;
`else
    localparam bit FRAC_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              en;
    logic              phase_clr;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CNT_W-1:0]  cfg_baud_val;
    logic [FRAC_W-1:0] cfg_baud_frac;
    logic              baud_tick;
    logic              xmit_pulse;
    logic [OVS_W-1:0]  ovs_phase;

    uart_baud_gen_frac #(
        .CNT_W    (CNT_W),
        .FRAC_W   (FRAC_W),
        .OVS_W    (OVS_W),
        .BAUD_RST (13'd3),
        .FRAC_RST (3'd0)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .en            (en),
        .phase_clr     (phase_clr),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_baud_val  (cfg_baud_val),
        .cfg_baud_frac (cfg_baud_frac),
        .baud_tick     (baud_tick),
        .xmit_pulse    (xmit_pulse),
        .ovs_phase     (ovs_phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        int bv;
        int fr;
        int span_frac;
        int span_int;
    } vec_t;

    vec_t vecs[6];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc;
    int   n_tick;
    int   n_xmit;
    int   tick_at[64];
    int   xmit_at[16];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock and sample just after the edge, logging tick/pulse cycles.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (baud_tick && n_tick < 64) begin
            tick_at[n_tick] = cyc;
            n_tick++;
        end
        if (xmit_pulse && n_xmit < 16) begin
            xmit_at[n_xmit] = cyc;
            n_xmit++;
        end
    endtask

    task automatic clear_log();
        cyc    = 0;
        n_tick = 0;
        n_xmit = 0;
        for (int i = 0; i < 64; i++) tick_at[i] = -1;
        for (int i = 0; i < 16; i++) xmit_at[i] = -1;
    endtask

    task automatic run_ticks(input string name, input int n, input int budget);
        int g;
        g = 0;
        while (n_tick < n && g < budget) begin
            step();
            g++;
        end
        check({name, "_tick_count"}, n_tick, n);
    endtask

    // With en low the offer is accepted on the first edge and applied on the second.
    task automatic configure(input int bv, input int fr);
        cfg_valid     = 1'b1;
        cfg_baud_val  = CNT_W'(bv);
        cfg_baud_frac = FRAC_W'(fr);
        step();
        cfg_valid = 1'b0;
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int g;
        int early;

        vecs[0] = '{bv: 3, fr: 0, span_frac: 32, span_int: 32};
        vecs[1] = '{bv: 3, fr: 4, span_frac: 36, span_int: 32};
        vecs[2] = '{bv: 3, fr: 7, span_frac: 39, span_int: 32};
        vecs[3] = '{bv: 0, fr: 0, span_frac: 8,  span_int: 8};
        vecs[4] = '{bv: 5, fr: 1, span_frac: 49, span_int: 48};
        vecs[5] = '{bv: 0, fr: 3, span_frac: 11, span_int: 8};

        reset_n       = 1'b0;
        en            = 1'b0;
        phase_clr     = 1'b0;
        cfg_valid     = 1'b0;
        cfg_baud_val  = '0;
        cfg_baud_frac = '0;
        clear_log();
        repeat (3) step();
        check("rst_tick", baud_tick, 0);
        check("rst_xmit", xmit_pulse, 0);
        check("rst_ovs", ovs_phase, 0);
        check("rst_ready", cfg_ready, 1);

        reset_n = 1'b1;
        en      = 1'b1;
        clear_log();
        run_ticks("rst_rel", 2, 20);
        check("rst_rel_first", tick_at[0], 1);
        check("rst_rel_second", tick_at[1], 5);

        for (int v = 0; v < 6; v++) begin
            en = 1'b0;
            configure(vecs[v].bv, vecs[v].fr);
            check($sformatf("vec%0d_ready", v), cfg_ready, 1);
            clear_log();
            en = 1'b1;
            run_ticks($sformatf("vec%0d", v), 9, 200);
            check($sformatf("vec%0d_first", v), tick_at[0], 1);
            check($sformatf("vec%0d_span", v), tick_at[8] - tick_at[0],
                  FRAC_ON ? vecs[v].span_frac : vecs[v].span_int);
            check($sformatf("vec%0d_noxmit", v), n_xmit, 0);
        end

        en = 1'b0;
        configure(3, 0);
        clear_log();
        en = 1'b1;
        run_ticks("xmit", 33, 300);
        check("xmit_first", xmit_at[0], 61);
        check("xmit_second", xmit_at[1], 125);
        check("xmit_count", n_xmit, 2);
        check("xmit_tick16", tick_at[15], 61);
        check("xmit_tick32", tick_at[31], 125);

        en = 1'b0;
        configure(3, 0);
        clear_log();
        en = 1'b1;
        g = 0;
        while (ovs_phase != 4'd5 && g < 100) begin
            step();
            g++;
        end
        check("recfg_phase5_cycle", cyc, 17);
        cfg_valid    = 1'b1;
        cfg_baud_val = 13'd9;
        cfg_baud_frac = '0;
        step();
        cfg_valid = 1'b0;
        check("recfg_ready_low", cfg_ready, 0);
        early = 0;
        g = 0;
        while (n_xmit == 0 && g < 200) begin
            step();
            g++;
            if (n_xmit == 0 && cfg_ready) early++;
        end
        check("recfg_ready_early", early, 0);
        check("recfg_ready_at_xmit", cfg_ready, 1);
        check("recfg_xmit", xmit_at[0], 61);
        run_ticks("recfg", 18, 100);
        check("recfg_old_period", tick_at[15] - tick_at[14], 4);
        check("recfg_new_period1", tick_at[16] - tick_at[15], 10);
        check("recfg_new_period2", tick_at[17] - tick_at[16], 10);

        en = 1'b0;
        configure(3, 0);
        clear_log();
        en = 1'b1;
        repeat (23) step();
        phase_clr = 1'b1;
        step();
        check("pclr_ovs", ovs_phase, 0);
        check("pclr_tick", baud_tick, 0);
        phase_clr = 1'b0;
        clear_log();
        step();
        check("pclr_tick_after", baud_tick, 1);
        check("pclr_ovs_after", ovs_phase, 1);
        run_ticks("pclr", 17, 200);
        check("pclr_tick16", tick_at[15], 61);
        check("pclr_xmit", xmit_at[0], 61);
        check("pclr_tick17", tick_at[16], 65);

        en = 1'b0;
        configure(7, 0);
        clear_log();
        en = 1'b1;
        repeat (30) step();
        cfg_valid    = 1'b1;
        cfg_baud_val = 13'd9;
        step();
        cfg_valid = 1'b0;
        check("rstmid_pend", cfg_ready, 0);
        repeat (3) step();
        reset_n = 1'b0;
        step();
        check("rstmid_tick", baud_tick, 0);
        check("rstmid_xmit", xmit_pulse, 0);
        check("rstmid_ovs", ovs_phase, 0);
        check("rstmid_ready", cfg_ready, 1);
        reset_n = 1'b1;
        clear_log();
        run_ticks("rstmid", 18, 200);
        check("rstmid_first", tick_at[0], 1);
        check("rstmid_period", tick_at[1] - tick_at[0], 4);
        check("rstmid_xmit", xmit_at[0], 61);
        check("rstmid_period_bit", tick_at[16] - tick_at[15], 4);
        check("rstmid_period_bit2", tick_at[17] - tick_at[16], 4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_baud_gen_frac.md
# uart_baud_gen_frac

Parametrised baud-rate generator for the UART cores: produces the oversample tick (`baud_tick`) and the per-bit transmit pulse (`xmit_pulse`) from the system clock. Generalises the fixed 13-bit / x16 / 3-bit-fraction generator to configurable counter width, oversample ratio and fraction width. The fraction is realised with a carry accumulator rather than fixed dither patterns. Adds a glitch-free runtime reconfiguration handshake, an enable, and a phase-clear input for receiver resynchronisation.

## Interface
- `CNT_W`, 13: width of integer divisor `baud_val`.
- `FRAC_W`, 3: width of fractional divisor `baud_frac` (units of 1/2^FRAC_W cycle per tick).
- `OVS_W`, 4: log2 of oversample ratio (4 → x16).
- `BAUD_RST`, 0: active divisor after reset.
- `FRAC_RST`, 0: active fraction after reset.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `en`  in  1  generator enable.
- `phase_clr`  in  1  restart tick and bit phase (RX start-edge resync).
- `cfg_valid`  in  1  new configuration offered.
- `cfg_ready`  out  1  shadow register free.
- `cfg_baud_val`  in  CNT_W  new integer divisor.
- `cfg_baud_frac`  in  FRAC_W  new fraction.
- `baud_tick`  out  1  one-cycle oversample pulse.
- `xmit_pulse`  out  1  one-cycle bit pulse, coincident with every 2^OVS_W-th `baud_tick`.
- `ovs_phase`  out  OVS_W  current oversample count.

## Operation
- Registers: `cnt` (CNT_W), `acc` (FRAC_W), `stretch` (1), `ovs_cntr` (OVS_W), active `baud_val`/`baud_frac`, shadow pair, `pend` (1).
- Reset (`reset_n`=0 at edge): `cnt`=0, `acc`=0, `stretch`=0, `ovs_cntr`=0, `baud_tick`=0, `xmit_pulse`=0, `pend`=0, `cfg_ready`=1, active = BAUD_RST/FRAC_RST.
- `en`=0: `cnt`, `acc`, `stretch`, `ovs_cntr` forced to 0; `baud_tick`=`xmit_pulse`=0; handshake still works.
- Per cycle, `en`=1, priority order:
  - `phase_clr`=1: `cnt`, `acc`, `stretch`, `ovs_cntr` ← 0; no tick this cycle.
  - `cnt`≠0: `cnt`←`cnt`−1, `baud_tick`←0.
  - `cnt`=0 and `stretch`=1: hold `cnt`, `stretch`←0, `baud_tick`←0 (one extra cycle).
  - `cnt`=0 and `stretch`=0 (reload): `cnt`←`baud_val`, `baud_tick`←1, `{stretch,acc}`←`acc`+`baud_frac` (FRAC_W+1 bit sum), `xmit_pulse`←(`ovs_cntr`=2^OVS_W−1), `ovs_cntr`←`ovs_cntr`+1 (wraps).
- `xmit_pulse`←0 in every non-reload cycle.
- Mean tick period = `baud_val`+1+`baud_frac`/2^FRAC_W cycles; `baud_val`=0, frac=0 → tick every cycle.
- Handshake: transfer when `cfg_valid`&`cfg_ready`; capture into shadow, `pend`←1, `cfg_ready`←0.
- Apply pending shadow at a bit boundary (a reload cycle whose `xmit_pulse` is set), or on any cycle with `en`=0 or `phase_clr`=1.
- On apply: active←shadow, `acc`←0, `stretch`←0, `pend`←0, `cfg_ready`←1.
- On a bit-boundary apply, that cycle's reload uses the new `baud_val`.
- `cfg_valid` held without `cfg_ready` is not lost; its data must be stable until accepted.

## Timing
- All outputs registered; no combinational input→output path.
- After reset release with `en`=1: first `baud_tick` in the first cycle after release (`cnt`=0).
- First `xmit_pulse` on the 2^OVS_W-th tick.
- After `en` rises, or `phase_clr` falls: first tick one cycle later.
- Config accepted at cycle N appears as divisor from the next bit boundary ≥ N+1.
- `cfg_ready` returns high the cycle after apply.

## Configuration
- `UART_BAUD_FRAC_EN` defined: accumulator, `stretch` and fractional path present as above.
- `UART_BAUD_FRAC_EN` undefined: `acc`/`stretch` removed; `cfg_baud_frac` and FRAC_RST ignored. Period exactly `baud_val`+1. Port list unchanged.

## Structure
- Shared package `uart_pkg`: default widths (CNT_W, FRAC_W, OVS_W), x16 oversample constant.
- Single module, no sub-modules; the handshake shadow is small enough to stay inline.

## Test plan
- `baud_val`=3, frac=0, OVS_W=4 → `baud_tick` every 4 cycles; `xmit_pulse` every 64 cycles, coincident with a tick.
- `baud_val`=3, frac=4, FRAC_W=3 → tick periods alternate 4,5; 8 ticks span 36 cycles.
- frac=7 → over 8 ticks, seven periods of 5 and one of 4 (39 cycles).
- Load `baud_val`=9 mid-bit (`ovs_phase`=5) → old period kept until `xmit_pulse`; then period 10; `cfg_ready` low throughout, high the cycle after.
- `phase_clr` pulse at arbitrary phase → `ovs_phase`=0; next tick 1 cycle after deassert; `xmit_pulse` 16 ticks later.
- `reset_n` low mid-count for 1 cycle → all outputs 0, active divisor = BAUD_RST, `cfg_ready`=1, pending config discarded.
